ps2_receiver: RTL and testbench

PS2_RECEIVER -- requirements
Module: ps2_receiver

---
 rtl/ps2_receiver_pkg.sv | 19 +
 rtl/ps2_receiver_clk_filter.sv | 46 ++++
 rtl/ps2_receiver.sv | 128 ++++++++++++
 tb/tb_ps2_receiver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_receiver_pkg.sv
// Shared constants, FSM encoding and parity helper for the PS/2 keyboard receiver.
package ps2_receiver_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_receiver_clk_filter.sv
// Two-flop synchronizers for both PS/2 lines plus a glitch filter on the clock line.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall_evt
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt    <= 1'b1;
            cnt         <= '0;
            fall_evt    <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            fall_evt    <= 1'b0;
            // Any sample matching the current level breaks the run of differing samples.
            if (clk_sync_q[1] == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync_q[1];
                cnt      <= '0;
                fall_evt <= clk_filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign data_sync = data_sync_q[1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: frames bytes, drops prefixes and key releases, presents make codes with a strobe.
module ps2_receiver
    import ps2_receiver_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000,
    parameter int STROBE_CYC  = 10000
) (
    input  logic       clk100Mhz,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key_code1,
    output logic [3:0] key_code0,
    output logic       strobe,
    output logic       frame_err,
    output rx_state_e  fsm_state
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int SW = $clog2(STROBE_CYC + 1);

    logic          data_sync;
    logic          fall_evt;
    rx_state_e     state;
    rx_state_e     state_next;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt;
    logic          parity_ok;
    logic          break_pending;
    logic          restart_pending;
    logic [TW-1:0] tcnt;
    logic [SW-1:0] scnt;
    logic          timeout;
    logic          byte_ok;
    logic          byte_bad;
    logic          is_make;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk       (clk100Mhz),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_sync (data_sync),
        .fall_evt  (fall_evt)
    );

    always_comb begin
        state_next = state;
        timeout    = (state != IDLE) && !fall_evt && (tcnt == TW'(TIMEOUT_CYC - 1));
        byte_ok    = (state == STOP) && fall_evt && data_sync && parity_ok;
        byte_bad   = (state == STOP) && fall_evt && !(data_sync && parity_ok);
        is_make    = byte_ok && (shift_q != PS2_EXT) && (shift_q != PS2_BRK) && !break_pending;
        if (timeout) begin
            state_next = IDLE;
        end else if (fall_evt) begin
            case (state)
                IDLE:    if (!data_sync) state_next = DATA;
                DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk100Mhz) begin
        if (!rst_n) begin
            state           <= IDLE;
            shift_q         <= '0;
            bit_cnt         <= '0;
            parity_ok       <= 1'b0;
            break_pending   <= 1'b0;
            restart_pending <= 1'b0;
            tcnt            <= '0;
            scnt            <= '0;
            key_code1       <= '0;
            key_code0       <= '0;
            strobe          <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            state     <= state_next;
            frame_err <= timeout || byte_bad;

            if (state == IDLE || fall_evt || timeout) tcnt <= '0;
            else                                      tcnt <= tcnt + 1'b1;

            if (fall_evt) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift_q <= {data_sync, shift_q[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: parity_ok <= odd_parity_ok(shift_q, data_sync);
                    default: ;
                endcase
            end

            if (byte_ok) begin
                if (shift_q == PS2_BRK)                      break_pending <= 1'b1;
                else if (shift_q != PS2_EXT && break_pending) break_pending <= 1'b0;
            end

            // A code arriving mid-strobe gets a one-clock low gap so the consumer sees a fresh edge.
            if (is_make) begin
                {key_code1, key_code0} <= shift_q;
                scnt            <= '0;
                strobe          <= !strobe;
                restart_pending <= strobe;
            end else if (restart_pending) begin
                restart_pending <= 1'b0;
                strobe          <= 1'b1;
                scnt            <= '0;
            end else if (strobe) begin
                if (scnt == SW'(STROBE_CYC - 1)) begin
                    strobe <= 1'b0;
                    scnt   <= '0;
                end else begin
                    scnt <= scnt + 1'b1;
                end
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed and randomized bench for ps2_receiver with a keyboard-level reference model.
module tb_ps2_receiver;
    import ps2_receiver_pkg::*;

    localparam int FLEN = 8;
    localparam int TOUT = 2000;
    localparam int SCYC = 1000;
    localparam int HALF = 20;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key_code1;
    logic [3:0] key_code0;
    logic       strobe;
    logic       frame_err;
    rx_state_e  fsm_state;

    ps2_receiver #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TOUT), .STROBE_CYC(SCYC)) u_dut (
        .clk100Mhz (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_code1 (key_code1),
        .key_code0 (key_code0),
        .strobe    (strobe),
        .frame_err (frame_err),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         len_q[$];
    int         gap_q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         exp_err = 0;
    int         err_seen = 0;
    int         err_wide = 0;
    int         err_cyc = 0;
    int         evt_cnt = 0;
    int         last_fall = 0;
    logic [7:0] m_code = 8'h00;
    bit         m_brk = 1'b0;

    // monitor, sampled on the falling clock edge
    logic prev_strobe = 1'b0;
    logic prev_err = 1'b0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    bit   fall_seen = 1'b0;

    always @(negedge clk) begin
        if (strobe && !prev_strobe) begin
            obs_q.push_back({key_code1, key_code0});
            if (fall_seen) gap_q.push_back(cyc - fall_cyc);
            rise_cyc = cyc;
        end
        if (!strobe && prev_strobe) begin
            len_q.push_back(cyc - rise_cyc);
            fall_cyc  = cyc;
            fall_seen = 1'b1;
        end
        if (frame_err) begin
            err_seen++;
            err_cyc = cyc;
            if (prev_err) err_wide++;
        end
        if (u_dut.fall_evt) evt_cnt++;
        prev_strobe = strobe;
        prev_err    = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF / 2);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        tick(HALF);
        ps2_clk = 1'b1;
        tick(HALF / 2);
    endtask

    // reference model: keyboard protocol rules on whole bytes
    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad) exp_err++;
        else if (b == 8'hE0) begin end
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (m_brk) m_brk = 1'b0;
        else begin
            exp_q.push_back(b);
            m_code = b;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int gap);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        model_frame(b, bad_par);
        tick(gap);
    endtask

    task automatic clear_all();
        exp_q.delete();
        obs_q.delete();
        len_q.delete();
        gap_q.delete();
        exp_err   = 0;
        err_seen  = 0;
        fall_seen = 1'b0;
    endtask

    task automatic settle_and_compare(input string tag, input bit check_len);
        tick(SCYC + 100);
        check({tag, "_strobes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_code"}, 32'(obs_q[i]), 32'(exp_q[i]));
        if (check_len)
            for (int i = 0; i < len_q.size(); i++)
                check({tag, "_strobe_len"}, 32'(len_q[i]), 32'(SCYC));
        check({tag, "_errs"}, 32'(err_seen), 32'(exp_err));
        check({tag, "_key_code"}, 32'({key_code1, key_code0}), 32'(m_code));
        clear_all();
    endtask

    initial begin
        logic [7:0] rb;
        bit         rbad;
        int         evt0;

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        tick(5);
        check("rst_kc1", 32'(key_code1), 32'h0);
        check("rst_kc0", 32'(key_code0), 32'h0);
        check("rst_strobe", 32'(strobe), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        rst_n = 1'b1;
        tick(5);
        clear_all();

        // single make code
        send_frame(8'h75, 1'b0, 20);
        tick(5);
        check("make75_kc1", 32'(key_code1), 32'h7);
        check("make75_kc0", 32'(key_code0), 32'h5);
        check("make75_strobe", 32'(strobe), 32'h1);
        settle_and_compare("make75", 1'b1);

        // extended prefix, then extended release
        send_frame(8'hE0, 1'b0, 40);
        send_frame(8'h75, 1'b0, 40);
        send_frame(8'hE0, 1'b0, 40);
        send_frame(8'hF0, 1'b0, 40);
        send_frame(8'h75, 1'b0, 40);
        settle_and_compare("ext", 1'b1);

        // parity error
        send_frame(8'h1B, 1'b1, 40);
        settle_and_compare("parity", 1'b1);

        // truncated frame runs into the timeout
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        evt0 = last_fall;
        tick(TOUT + 300);
        check("tmo_err_count", 32'(err_seen), 32'd1);
        check("tmo_latency", 32'((err_cyc - evt0) >= TOUT && (err_cyc - evt0) <= TOUT + FLEN + 8), 32'd1);
        check("tmo_state", 32'(fsm_state), 32'(IDLE));
        clear_all();
        send_frame(8'h2D, 1'b0, 40);
        settle_and_compare("after_tmo", 1'b1);

        // second code while strobe is still high
        send_frame(8'h6B, 1'b0, 40);
        send_frame(8'h72, 1'b0, 40);
        tick(SCYC + 100);
        check("back2back_strobes", 32'(obs_q.size()), 32'd2);
        check("back2back_gaps", 32'(gap_q.size()), 32'd1);
        check("back2back_lens", 32'(len_q.size()), 32'd2);
        if (gap_q.size() >= 1) check("back2back_gap", 32'(gap_q[0]), 32'd1);
        if (len_q.size() >= 2) begin
            check("back2back_len0_short", 32'(len_q[0] < SCYC), 32'd1);
            check("back2back_len1", 32'(len_q[1]), 32'(SCYC));
        end
        check("back2back_code", 32'({key_code1, key_code0}), 32'h72);
        check("back2back_errs", 32'(err_seen), 32'd0);
        m_code = 8'h72;
        clear_all();

        // randomized traffic, including releases, prefixes and corrupted parity
        for (int n = 0; n < 8; n++) begin
            rb   = 8'($urandom_range(0, 255));
            rbad = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) send_frame(8'hF0, 1'b0, 40);
            if ($urandom_range(0, 5) == 0) send_frame(8'hE0, 1'b0, 40);
            send_frame(rb, rbad, 40);
            settle_and_compare("rand", 1'b1);
        end
        // typematic repeat of the same key
        send_frame(8'h1C, 1'b0, 40);
        settle_and_compare("repeat_a", 1'b1);
        send_frame(8'h1C, 1'b0, 40);
        settle_and_compare("repeat_b", 1'b1);

        // short glitches on the clock line never produce a sample
        evt0     = evt_cnt;
        ps2_data = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(20);
        end
        ps2_data = 1'b1;
        tick(10);
        check("glitch_events", 32'(evt_cnt - evt0), 32'd0);
        check("glitch_state", 32'(fsm_state), 32'(IDLE));
        check("glitch_errs", 32'(err_seen), 32'd0);

        // reset in the middle of a frame while strobe is high
        clear_all();
        send_frame(8'h3C, 1'b0, 20);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_n = 1'b0;
        tick(3);
        check("midrst_kc1", 32'(key_code1), 32'h0);
        check("midrst_kc0", 32'(key_code0), 32'h0);
        check("midrst_strobe", 32'(strobe), 32'h0);
        check("midrst_err", 32'(frame_err), 32'h0);
        check("midrst_state", 32'(fsm_state), 32'(IDLE));
        rst_n = 1'b1;
        ps2_data = 1'b1;
        m_code = 8'h00;
        m_brk  = 1'b0;
        tick(10);
        clear_all();
        send_frame(8'h5A, 1'b0, 40);
        settle_and_compare("after_rst", 1'b1);

        check("err_pulse_width", 32'(err_wide), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
